branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with per-entry 2-bit saturating direction counters, for the IF stage of the 5-stage MIPS pipeline.
- Replaces the static "predict not-taken, resolve in ID, flush IF/ID" scheme.
- IF looks up the current PC combinationally and gets a next-PC guess.
- ID writes each resolved branch back one cycle later.
- Saturating statistics counters for branch count and mispredict count.

Parameters:
- ENTRIES, 16: number of BTB entries; power of 2, at least 2. IDX_W = clog2(ENTRIES).
- ADDR_W, 32: PC width.
- STAT_W, 16: width of each statistics counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  ADDR_W  PC of the instruction in IF.
- pred_hit  output  1  valid entry with matching tag exists for lookup_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  ADDR_W  predicted next PC.
- upd_valid  input  1  a branch is resolved in ID this cycle.
- upd_pc  input  ADDR_W  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_target  input  ADDR_W  actual branch target.
- upd_pred_taken  input  1  pred_taken that IF produced for this branch.
- upd_pred_target  input  ADDR_W  pred_target that IF produced for this branch.
- flush_inv  input  1  invalidate all entries.
- mispredict  output  1  combinational; high when the current update was mispredicted.
- stat_branches  output  STAT_W  registered count of updates.
- stat_mispredicts  output  STAT_W  registered count of mispredicts.

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high. On a rst edge:
  - all valid bits and direction counters clear to 0;
  - stat_branches and stat_mispredicts clear to 0;
  - targets and tags are don't-care.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Address split: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx]==tag(lookup_pc)).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = target[idx] if pred_taken, else lookup_pc+4, modulo 2^ADDR_W.
- Update (on a clk edge when upd_valid=1 and rst=0, with index/tag taken from upd_pc):
  - Hit, taken: ctr = min(ctr+1, 3); target <= upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate the entry, overwriting any aliasing entry: valid=1, tag, target=upd_target, ctr=2 (weakly taken).
  - Miss, not taken: no state change.
- Mispredict: mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_taken & (upd_pred_target != upd_target))).
- Statistics:
  - stat_branches increments on each upd_valid edge.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at all-ones; no wrap.
- No bypass: a lookup and an update in the same cycle to the same index see the pre-update contents. The new contents are visible from the next cycle.
- flush_inv=1 at an edge:
  - clears all valid bits; counters and targets are left stale;
  - takes priority over a simultaneous update, so there is no allocation or counter change that cycle;
  - statistics still count that update.
- Precedence: rst > flush_inv > update.
- Storage: per-entry registers (valid, tag, 2-bit ctr, target). Single write port. Asynchronous read.

Test Plan (ENTRIES=16, ADDR_W=32, STAT_W=16 unless stated):
- Reset:
  - Stimulus: assert rst 1 cycle, then lookup_pc=0x40.
  - Required: pred_hit=0, pred_taken=0, pred_target=0x44, both stats 0.
- Allocate:
  - Stimulus: upd pc=0x40, taken=1, target=0x100, pred_taken=0.
  - Required: mispredict=1 that cycle.
  - Required next cycle, lookup 0x40: pred_hit=1, pred_taken=1, pred_target=0x100; stat_branches=1, stat_mispredicts=1.
- Counter saturation:
  - Stimulus: three not-taken updates to 0x40.
  - Required: ctr goes 2 -> 1 -> 0 -> 0. From the first update onward, pred_taken=0 and pred_target=0x44 while pred_hit stays 1.
  - Stimulus: then four taken updates.
  - Required: pred_taken=1 after the second; ctr saturates at 3.
- Aliasing:
  - Setup: 0x40 and 0x80 share index 0 with different tags.
  - Stimulus: taken update to 0x80 with target=0x200.
  - Required: lookup 0x40 gives pred_hit=0, pred_target=0x44; lookup 0x80 gives hit, target 0x200.
- Same-cycle events:
  - Stimulus: lookup 0x40 during a taken update that changes its target to 0x300.
  - Required: old target 0x100 that cycle, 0x300 the next.
  - Stimulus: flush_inv together with a taken update to 0x60.
  - Required: every lookup misses afterwards; stat_branches still increments.
- Stat saturation and reset mid-operation (STAT_W=2):
  - Stimulus: 5 mispredicted updates.
  - Required: both stats stick at 3.
  - Stimulus: assert rst during an update.
  - Required: stats 0, all entries invalid, no allocation.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating direction counters for the IF stage.
// Lookup is asynchronous; ID writes resolved branches back through a single write port.

module btb_entry #(
  parameter int TAG_W  = 26,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic              taken_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              dir_o,
  output logic [ADDR_W-1:0] target_o
);
  logic              valid_q, valid_d;
  logic [1:0]        ctr_q, ctr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              hit;

  assign hit = valid_q && (tag_q == tag_i);

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (we_i) begin
      if (hit) begin
        if (taken_i) begin
          ctr_d    = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'b01;
          target_d = target_i;
        end else begin
          ctr_d    = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'b01;
        end
      end else if (taken_i) begin
        // allocation overwrites whatever aliased into this slot, starting weakly taken
        valid_d  = 1'b1;
        tag_d    = tag_i;
        target_d = target_i;
        ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctr_q   <= 2'b00;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign dir_o    = ctr_q[1];
  assign target_o = target_q;
endmodule

module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush_inv,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0]             dir;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] target;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             unused_pc_lsbs;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^upd_pc[1:0];

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    btb_entry #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_inv),
      .we_i     (upd_valid && (upd_idx == IDX_W'(e))),
      .taken_i  (upd_taken),
      .tag_i    (upd_tag),
      .target_i (upd_target),
      .valid_o  (valid[e]),
      .tag_o    (tag[e]),
      .dir_o    (dir[e]),
      .target_o (target[e])
    );
  end

  // no bypass: a same-cycle update is only seen from the next cycle
  assign pred_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && dir[lk_idx];
  assign pred_target = pred_taken ? target[lk_idx] : lookup_pc + ADDR_W'(4);

  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

  logic [STAT_W-1:0] br_q, br_d, mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_valid && (br_q != '1)) br_d = br_q + 1'b1;
    if (mispredict && (mp_q != '1)) mp_d = mp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench: main BTB instance (16/32/16) plus a STAT_W=2 instance for stat saturation.

module tb_branch_target_predictor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance
  logic        rst, upd_valid, upd_taken, upd_pred_taken, flush_inv;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target;
  logic [15:0] stat_branches, stat_mispredicts;

  branch_target_predictor #(.ENTRIES(16), .ADDR_W(32), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_inv(flush_inv),
    .mispredict(mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  // narrow-stat instance
  logic        s_rst, s_upd_valid, s_upd_taken, s_upd_pred_taken, s_flush_inv;
  logic [31:0] s_lookup_pc, s_upd_pc, s_upd_target, s_upd_pred_target;
  logic        s_pred_hit, s_pred_taken, s_mispredict;
  logic [31:0] s_pred_target;
  logic [1:0]  s_stat_branches, s_stat_mispredicts;

  branch_target_predictor #(.ENTRIES(16), .ADDR_W(32), .STAT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .lookup_pc(s_lookup_pc),
    .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
    .upd_target(s_upd_target), .upd_pred_taken(s_upd_pred_taken),
    .upd_pred_target(s_upd_pred_target), .flush_inv(s_flush_inv),
    .mispredict(s_mispredict), .stat_branches(s_stat_branches),
    .stat_mispredicts(s_stat_mispredicts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0; flush_inv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    tick();
    rst = 1'b0; s_rst = 1'b0;
    lookup_pc = 32'h40; #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", pred_hit); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    total++; if (pred_target !== 32'h44) begin bad++; $display("FAIL reset_target got=%h exp=44", pred_target); end
    total++; if (stat_branches !== 16'd0 || stat_mispredicts !== 16'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    lookup_pc = 32'hFFFF_FFFC; #1;
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", pred_target); end
  endtask

  task automatic test_allocate();
    lookup_pc = 32'h40;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44); #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%b exp=1", mispredict); end
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL alloc_no_bypass got=%b exp=0", pred_hit); end
    tick(); idle(); #1;
    total++; if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h100) begin
      bad++; $display("FAIL alloc_lookup got=%b%b %h exp=11 100", pred_hit, pred_taken, pred_target); end
    total++; if (stat_branches !== 16'd1 || stat_mispredicts !== 16'd1) begin
      bad++; $display("FAIL alloc_stats got=%0d/%0d exp=1/1", stat_branches, stat_mispredicts); end
    // not-taken miss must not allocate
    upd(32'h44, 1'b0, 32'h0, 1'b0, 32'h48); tick(); idle();
    lookup_pc = 32'h44; #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL nt_miss_alloc got=%b exp=0", pred_hit); end
    lookup_pc = 32'h40; #1;
  endtask

  task automatic test_counter();
    // ctr 2 -> 1 -> 0 -> 0; predictions fed back as IF would have produced them
    logic       ptk [3]  = '{1'b1, 1'b0, 1'b0};
    logic       mis [3]  = '{1'b1, 1'b0, 1'b0};
    logic       tptk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       tafter [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 1'b0, 32'h0, ptk[i], ptk[i] ? 32'h100 : 32'h44); #1;
      total++; if (mispredict !== mis[i]) begin bad++; $display("FAIL nt_mispredict%0d got=%b exp=%b", i, mispredict, mis[i]); end
      tick(); idle(); #1;
      total++; if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h44) begin
        bad++; $display("FAIL nt_step%0d got=%b%b %h exp=10 44", i, pred_hit, pred_taken, pred_target); end
    end
    for (int i = 0; i < 4; i++) begin
      upd(32'h40, 1'b1, 32'h100, tptk[i], tptk[i] ? 32'h100 : 32'h44);
      tick(); idle(); #1;
      total++; if (pred_taken !== tafter[i]) begin bad++; $display("FAIL tk_step%0d got=%b exp=%b", i, pred_taken, tafter[i]); end
    end
    // one not-taken from saturated 3 leaves 2, still predicting taken
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); tick(); idle(); #1;
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      bad++; $display("FAIL ctr_sat got=%b %h exp=1 100", pred_taken, pred_target); end
    total++; if (stat_branches !== 16'd10 || stat_mispredicts !== 16'd5) begin
      bad++; $display("FAIL ctr_stats got=%0d/%0d exp=10/5", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_alias();
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84); tick(); idle();
    lookup_pc = 32'h40; #1;
    total++; if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
      bad++; $display("FAIL alias_old got=%b %h exp=0 44", pred_hit, pred_target); end
    lookup_pc = 32'h80; #1;
    total++; if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h200) begin
      bad++; $display("FAIL alias_new got=%b%b %h exp=11 200", pred_hit, pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44); tick(); idle();
    lookup_pc = 32'h40;
    upd(32'h40, 1'b1, 32'h300, 1'b1, 32'h100); #1;
    total++; if (pred_target !== 32'h100) begin bad++; $display("FAIL same_cycle_old got=%h exp=100", pred_target); end
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL target_mispredict got=%b exp=1", mispredict); end
    tick(); idle(); #1;
    total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL same_cycle_new got=%h exp=300", pred_target); end
    // flush beats the simultaneous allocation but stats still count it
    upd(32'h60, 1'b1, 32'h500, 1'b0, 32'h64); flush_inv = 1'b1; tick(); idle();
    lookup_pc = 32'h60; #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL flush_alloc got=%b exp=0", pred_hit); end
    lookup_pc = 32'h40; #1;
    total++; if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
      bad++; $display("FAIL flush_40 got=%b %h exp=0 44", pred_hit, pred_target); end
    lookup_pc = 32'h80; #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL flush_80 got=%b exp=0", pred_hit); end
    total++; if (stat_branches !== 16'd14 || stat_mispredicts !== 16'd9) begin
      bad++; $display("FAIL flush_stats got=%0d/%0d exp=14/9", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_stat_sat();
    logic [1:0] exp_n;
    s_lookup_pc = 32'h40;
    for (int i = 1; i <= 5; i++) begin
      s_upd_valid = 1'b1; s_upd_pc = 32'h40; s_upd_taken = 1'b1; s_upd_target = 32'h100;
      s_upd_pred_taken = 1'b0; s_upd_pred_target = 32'h44;
      tick();
      exp_n = (i > 3) ? 2'd3 : 2'(i);
      total++; if (s_stat_branches !== exp_n || s_stat_mispredicts !== exp_n) begin
        bad++; $display("FAIL stat_sat%0d got=%0d/%0d exp=%0d/%0d", i, s_stat_branches, s_stat_mispredicts, exp_n, exp_n); end
    end
    s_upd_valid = 1'b0; #1;
    total++; if (s_pred_hit !== 1'b1) begin bad++; $display("FAIL s_hit_before_rst got=%b exp=1", s_pred_hit); end
    // reset during an update: nothing allocated
    s_rst = 1'b1; s_upd_valid = 1'b1; s_upd_pc = 32'hC0; s_upd_target = 32'h700;
    tick();
    s_rst = 1'b0; s_upd_valid = 1'b0; #1;
    total++; if (s_stat_branches !== 2'd0 || s_stat_mispredicts !== 2'd0) begin
      bad++; $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", s_stat_branches, s_stat_mispredicts); end
    total++; if (s_pred_hit !== 1'b0 || s_pred_target !== 32'h44) begin
      bad++; $display("FAIL rst_mid_40 got=%b %h exp=0 44", s_pred_hit, s_pred_target); end
    s_lookup_pc = 32'hC0; #1;
    total++; if (s_pred_hit !== 1'b0) begin bad++; $display("FAIL rst_mid_alloc got=%b exp=0", s_pred_hit); end
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; flush_inv = 1'b0; lookup_pc = '0;
    s_rst = 1'b1; s_upd_valid = 1'b0; s_upd_pc = '0; s_upd_taken = 1'b0; s_upd_target = '0;
    s_upd_pred_taken = 1'b0; s_upd_pred_target = '0; s_flush_inv = 1'b0; s_lookup_pc = '0;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_stat_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
